sysid_boot_check: RTL and testbench
===================================

# sysid_boot_check

Avalon-MM master that sits directly downstream of the system ID slave and consumes its two read-only words. On a start pulse it reads the system ID (address 0) and the build timestamp (address 1), compares both against the values the software build expects, and reports pass/fail. It gates HPS/bridge bring-up logic so that a mismatched FPGA image is flagged before software touches the fabric.

## Interface
Parameters:
- EXPECTED_ID, 32'hACD51302, system ID word expected at address 0
- EXPECTED_TS, 32'h56316AFA, timestamp word expected at address 1
- TIMEOUT_CYCLES, 256, max consecutive waitrequest cycles per read (only with timeout compiled in); legal range 1..65535

Ports:
- clock  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- start  in  1  level-sampled request; a rising check begins when sampled high in IDLE
- avm_address  out  1  0 = ID word, 1 = timestamp word
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall; transfer completes on a cycle with avm_read=1 and avm_waitrequest=0
- avm_readdata  in  32  read data, valid in the completing cycle (zero read latency)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when a check finishes (pass, fail or timeout)
- pass  out  1  both words matched; held until next accepted start
- id_ok  out  1  ID word matched; held
- ts_ok  out  1  timestamp word matched; held
- timeout  out  1  check aborted by timeout; held
- read_id  out  32  captured ID word; held
- read_ts  out  32  captured timestamp word; held

## Operation
- Reset values: all outputs 0, avm_address 0, state IDLE; timeout counter 0.
- States: IDLE, RD_ID, RD_TS, CHECK, DONE.
- IDLE: start=1 at an edge -> RD_ID; pass/id_ok/ts_ok/timeout cleared at the same edge; read_id/read_ts retained until overwritten.
- RD_ID: avm_read=1, avm_address=0. On completing cycle, capture avm_readdata into read_id -> RD_TS.
- RD_TS: avm_read=1, avm_address=1. On completing cycle, capture into read_ts -> CHECK.
- CHECK: register id_ok = (read_id==EXPECTED_ID), ts_ok = (read_ts==EXPECTED_TS), pass = id_ok & ts_ok -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- start while not IDLE ignored; start held high re-triggers a new check from IDLE.
- avm_address and avm_read are registered; they must stay stable while avm_waitrequest=1.
- Timeout (when compiled in): counter increments each RD_ID/RD_TS cycle with avm_waitrequest=1, clears on completion or state change. Reaching TIMEOUT_CYCLES: deassert avm_read next cycle, set timeout=1, pass/id_ok/ts_ok=0, go to DONE.
- Reset mid-transfer: avm_read drops asynchronously, no result reported.

## Timing
- Zero wait states: start sampled at edge k; ID accepted at k+1, timestamp at k+2, results registered at k+3; done high for the cycle after edge k+3. Total latency 3 + W cycles, W = total waitrequest cycles.
- busy high from edge k until edge k+3+W+1 (falls with done).
- Results valid from the cycle done asserts onward.
- Timeout: done asserts 2 cycles after the TIMEOUT_CYCLES-th stalled cycle.

## Configuration
- SYSID_BOOT_CHECK_TIMEOUT_EN defined: timeout counter and abort path present, as above.
- Undefined: no counter; reads wait indefinitely on avm_waitrequest; timeout tied 0; TIMEOUT_CYCLES unused.

## Test plan
- Zero-wait slave returns 0xACD51302 / 0x56316AFA -> done 3 cycles after start, pass=1, id_ok=1, ts_ok=1, read_id/read_ts match.
- Slave returns 0xACD51302 / 0x00000000 -> done, id_ok=1, ts_ok=0, pass=0, read_ts=0.
- waitrequest held 5 cycles on each read -> done at cycle 13, address stable during stalls, pass=1.
- With _EN, TIMEOUT_CYCLES=8, waitrequest stuck high -> avm_read drops, timeout=1, pass=0, single done pulse; without _EN, avm_read stays high indefinitely.
- start pulsed again during RD_TS -> ignored, exactly one done; start held high -> back-to-back checks, flags cleared at each accept.
- reset asserted mid-RD_ID -> all outputs 0 immediately, state IDLE, no done.

Source files
------------

// File: rtl/sysid_boot_check.sv
// Reads the system ID and build timestamp words over Avalon-MM and flags whether they match the expected image.
// Optional read-stall timeout is compiled in with SYSID_BOOT_CHECK_TIMEOUT_EN.
module sysid_boot_check #(
  parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
  parameter logic [31:0] EXPECTED_TS    = 32'h56316AFA,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] read_id,
  output logic [31:0] read_ts
);

  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, DONE} state_t;

  state_t      state_q, state_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_address_q, avm_address_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic        abort_q, abort_d;
  logic [31:0] read_id_q, read_id_d;
  logic [31:0] read_ts_q, read_ts_d;
  logic        reading, stall, xfer, abort_hit;

  assign reading = (state_q == RD_ID) || (state_q == RD_TS);
  assign stall   = reading && avm_read_q && avm_waitrequest;
  assign xfer    = reading && avm_read_q && !avm_waitrequest;

`ifdef SYSID_BOOT_CHECK_TIMEOUT_EN
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;

  // Abort at the edge that ends the TIMEOUT_CYCLES-th stalled cycle.
  assign abort_hit = stall && (cnt_q == STALL_LAST);
  assign cnt_d     = (stall && !abort_hit) ? cnt_q + 16'd1 : 16'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  // Keeps the parameter referenced in builds without the timeout path.
  assign abort_hit = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d       = state_q;
    avm_read_d    = avm_read_q;
    avm_address_d = avm_address_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    pass_d        = pass_q;
    id_ok_d       = id_ok_q;
    ts_ok_d       = ts_ok_q;
    timeout_d     = timeout_q;
    abort_d       = abort_q;
    read_id_d     = read_id_q;
    read_ts_d     = read_ts_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = RD_ID;
          avm_read_d    = 1'b1;
          avm_address_d = 1'b0;
          busy_d        = 1'b1;
          pass_d        = 1'b0;
          id_ok_d       = 1'b0;
          ts_ok_d       = 1'b0;
          timeout_d     = 1'b0;
          abort_d       = 1'b0;
        end
      end
      RD_ID: begin
        if (xfer) begin
          read_id_d     = avm_readdata;
          avm_address_d = 1'b1;
          state_d       = RD_TS;
        end else if (abort_hit) begin
          avm_read_d = 1'b0;
          abort_d    = 1'b1;
          state_d    = CHECK;
        end
      end
      RD_TS: begin
        if (xfer) begin
          read_ts_d  = avm_readdata;
          avm_read_d = 1'b0;
          state_d    = CHECK;
        end else if (abort_hit) begin
          avm_read_d = 1'b0;
          abort_d    = 1'b1;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (abort_q) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
        end else begin
          id_ok_d = (read_id_q == EXPECTED_ID);
          ts_ok_d = (read_ts_q == EXPECTED_TS);
          pass_d  = (read_id_q == EXPECTED_ID) && (read_ts_q == EXPECTED_TS);
        end
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      timeout_q     <= 1'b0;
      abort_q       <= 1'b0;
      read_id_q     <= '0;
      read_ts_q     <= '0;
    end else begin
      state_q       <= state_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      id_ok_q       <= id_ok_d;
      ts_ok_q       <= ts_ok_d;
      timeout_q     <= timeout_d;
      abort_q       <= abort_d;
      read_id_q     <= read_id_d;
      read_ts_q     <= read_ts_d;
    end
  end

  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign read_id     = read_id_q;
  assign read_ts     = read_ts_q;

endmodule

// File: tb/tb_sysid_boot_check.sv
// Self-checking bench for sysid_boot_check: randomized slave data/stalls against a latency/compare model.
module tb_sysid_boot_check;
  localparam logic [31:0] EXP_ID = 32'hACD51302;
  localparam logic [31:0] EXP_TS = 32'h56316AFA;
  localparam int TO_CYC = 8;

  logic clock = 0, reset = 1, start = 0;
  logic avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic busy, done, pass, id_ok, ts_ok, timeout;
  logic [31:0] read_id, read_ts;

  logic [31:0] id_val = 0, ts_val = 0;
  logic stuck = 0;
  int stall_n = 0, wcnt = 0;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    int dn; int ndone; int addr_err; int rd_drop;
    logic busy0; logic busy_end;
    logic p; logic io; logic tso; logic to;
    logic [31:0] rid; logic [31:0] rts;
  } obs_t;

  sysid_boot_check #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .busy(busy), .done(done), .pass(pass), .id_ok(id_ok),
    .ts_ok(ts_ok), .timeout(timeout), .read_id(read_id), .read_ts(read_ts));

  always #5 clock = ~clock;

  // Slave: stalls each read for stall_n cycles (or forever while stuck), zero read latency.
  assign avm_waitrequest = stuck | (avm_read & (wcnt < stall_n));
  assign avm_readdata    = avm_address ? ts_val : id_val;
  always @(posedge clock) begin
    if (!avm_read || !avm_waitrequest) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // Pulse start, then observe negedge by negedge (n = edges after the accepting edge).
  task automatic run_obs(input logic [31:0] idv, input logic [31:0] tsv, input int s,
                         input int poke, output obs_t o);
    int n;
    logic prev_stall, prev_addr;
    id_val = idv; ts_val = tsv; stall_n = s;
    o.dn = -1; o.ndone = 0; o.addr_err = 0; o.rd_drop = -1;
    o.p = 1'bx; o.io = 1'bx; o.tso = 1'bx; o.to = 1'bx; o.rid = 'x; o.rts = 'x;
    @(negedge clock); start = 1;
    @(negedge clock); start = 0;
    o.busy0 = busy;
    n = 0; prev_stall = 0; prev_addr = 0;
    while (n < 60) begin
      if (done === 1'b1) begin
        o.ndone++;
        if (o.dn < 0) begin
          o.dn = n; o.p = pass; o.io = id_ok; o.tso = ts_ok; o.to = timeout;
          o.rid = read_id; o.rts = read_ts;
        end
      end
      if (avm_read !== 1'b1 && o.rd_drop < 0) o.rd_drop = n;
      if (prev_stall && avm_address !== prev_addr) o.addr_err++;
      prev_stall = avm_read && avm_waitrequest;
      prev_addr = avm_address;
      if (o.dn >= 0 && n >= o.dn + 3) break;
      start = (n == poke);
      @(negedge clock); n++;
    end
    start = 0;
    o.busy_end = busy;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if ({avm_read, avm_address, busy, done, pass, id_ok, ts_ok, timeout} !== 8'h00) begin n_bad++; $display("FAIL reset_ctrl got=%b want=00000000", {avm_read, avm_address, busy, done, pass, id_ok, ts_ok, timeout}); end
    n_cmp++; if ({read_id, read_ts} !== 64'h0) begin n_bad++; $display("FAIL reset_data got=%h want=0", {read_id, read_ts}); end
    @(negedge clock); reset = 0;
    @(negedge clock);
  endtask

  task automatic test_zero_wait;
    obs_t o;
    run_obs(EXP_ID, EXP_TS, 0, -1, o);
    n_cmp++; if (o.dn !== 3) begin n_bad++; $display("FAIL zw_latency got=%0d want=3", o.dn); end
    n_cmp++; if (o.busy0 !== 1'b1) begin n_bad++; $display("FAIL zw_busy got=%b want=1", o.busy0); end
    n_cmp++; if ({o.p, o.io, o.tso, o.to} !== 4'b1110) begin n_bad++; $display("FAIL zw_flags got=%b want=1110", {o.p, o.io, o.tso, o.to}); end
    n_cmp++; if (o.rid !== EXP_ID || o.rts !== EXP_TS) begin n_bad++; $display("FAIL zw_words got=%h/%h want=%h/%h", o.rid, o.rts, EXP_ID, EXP_TS); end
    n_cmp++; if (o.ndone !== 1 || o.busy_end !== 1'b0) begin n_bad++; $display("FAIL zw_single_done got=%0d/%b want=1/0", o.ndone, o.busy_end); end
  endtask

  task automatic test_ts_mismatch;
    obs_t o;
    run_obs(EXP_ID, 32'h0, 0, -1, o);
    n_cmp++; if (o.dn !== 3) begin n_bad++; $display("FAIL tsm_latency got=%0d want=3", o.dn); end
    n_cmp++; if ({o.p, o.io, o.tso} !== 3'b010) begin n_bad++; $display("FAIL tsm_flags got=%b want=010", {o.p, o.io, o.tso}); end
    n_cmp++; if (o.rts !== 32'h0) begin n_bad++; $display("FAIL tsm_read_ts got=%h want=0", o.rts); end
  endtask

  task automatic test_stall5;
    obs_t o;
    run_obs(EXP_ID, EXP_TS, 5, -1, o);
    n_cmp++; if (o.dn !== 13) begin n_bad++; $display("FAIL st5_latency got=%0d want=13", o.dn); end
    n_cmp++; if (o.addr_err !== 0) begin n_bad++; $display("FAIL st5_addr_stable got=%0d want=0", o.addr_err); end
    n_cmp++; if (o.p !== 1'b1) begin n_bad++; $display("FAIL st5_pass got=%b want=1", o.p); end
  endtask

  task automatic test_random;
    obs_t o;
    logic [31:0] idv, tsv;
    int s;
    for (int i = 0; i < 12; i++) begin
      idv = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
      tsv = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
      s = $urandom_range(0, 4);
      run_obs(idv, tsv, s, -1, o);
      n_cmp++; if (o.dn !== 3 + 2 * s) begin n_bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, o.dn, 3 + 2 * s); end
      n_cmp++; if (o.io !== (idv == EXP_ID) || o.tso !== (tsv == EXP_TS) || o.p !== (idv == EXP_ID && tsv == EXP_TS) || o.to !== 1'b0) begin
        n_bad++; $display("FAIL rnd%0d_flags got=%b%b%b%b want=%b%b%b0", i, o.p, o.io, o.tso, o.to, idv == EXP_ID && tsv == EXP_TS, idv == EXP_ID, tsv == EXP_TS); end
      n_cmp++; if (o.rid !== idv || o.rts !== tsv) begin n_bad++; $display("FAIL rnd%0d_words got=%h/%h want=%h/%h", i, o.rid, o.rts, idv, tsv); end
      n_cmp++; if (o.addr_err !== 0 || o.ndone !== 1) begin n_bad++; $display("FAIL rnd%0d_proto got=%0d/%0d want=0/1", i, o.addr_err, o.ndone); end
    end
  endtask

  task automatic test_start_ignored;
    obs_t o;
    run_obs(EXP_ID, EXP_TS, 3, 5, o);
    n_cmp++; if (o.ndone !== 1 || o.dn !== 9) begin n_bad++; $display("FAIL ign_done got=%0d@%0d want=1@9", o.ndone, o.dn); end
    n_cmp++; if (o.busy_end !== 1'b0) begin n_bad++; $display("FAIL ign_no_retrigger got=%b want=0", o.busy_end); end
  endtask

  task automatic test_back_to_back;
    int d1, d2, nd;
    logic p3, p5, ts8;
    id_val = EXP_ID; ts_val = EXP_TS; stall_n = 0;
    d1 = -1; d2 = -1; nd = 0; p3 = 1'bx; p5 = 1'bx; ts8 = 1'bx;
    @(negedge clock); start = 1;
    @(negedge clock);
    for (int n = 0; n < 12; n++) begin
      if (done === 1'b1) begin nd++; if (d1 < 0) d1 = n; else if (d2 < 0) d2 = n; end
      if (n == 3) begin p3 = pass; ts_val = 32'h0; end
      if (n == 5) p5 = pass;
      if (n == 8) begin ts8 = ts_ok; start = 0; end
      @(negedge clock);
    end
    n_cmp++; if (d1 !== 3 || d2 !== 8 || nd !== 2) begin n_bad++; $display("FAIL b2b_done got=%0d,%0d n=%0d want=3,8 n=2", d1, d2, nd); end
    n_cmp++; if (p3 !== 1'b1 || p5 !== 1'b0) begin n_bad++; $display("FAIL b2b_clear got=%b%b want=10", p3, p5); end
    n_cmp++; if (ts8 !== 1'b0) begin n_bad++; $display("FAIL b2b_second_ts got=%b want=0", ts8); end
  endtask

`ifdef SYSID_BOOT_CHECK_TIMEOUT_EN
  task automatic test_timeout;
    obs_t o;
    stuck = 1;
    run_obs(EXP_ID, EXP_TS, 0, -1, o);
    stuck = 0;
    n_cmp++; if (o.rd_drop !== TO_CYC) begin n_bad++; $display("FAIL to_read_drop got=%0d want=%0d", o.rd_drop, TO_CYC); end
    n_cmp++; if (o.dn !== TO_CYC + 1 || o.ndone !== 1) begin n_bad++; $display("FAIL to_done got=%0d x%0d want=%0d x1", o.dn, o.ndone, TO_CYC + 1); end
    n_cmp++; if ({o.p, o.io, o.tso, o.to} !== 4'b0001) begin n_bad++; $display("FAIL to_flags got=%b want=0001", {o.p, o.io, o.tso, o.to}); end
  endtask
`else
  task automatic test_timeout;
    int bad, dn;
    id_val = EXP_ID; ts_val = EXP_TS; stall_n = 0; stuck = 1; bad = 0; dn = -1;
    @(negedge clock); start = 1;
    @(negedge clock); start = 0;
    for (int n = 0; n < 40; n++) begin
      if (avm_read !== 1'b1 || done !== 1'b0) bad++;
      @(negedge clock);
    end
    stuck = 0;
    for (int n = 0; n < 10; n++) begin
      if (done === 1'b1 && dn < 0) begin dn = n; end
      if (dn < 0) @(negedge clock);
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL noto_read_held got=%0d want=0", bad); end
    n_cmp++; if (dn < 0 || pass !== 1'b1 || timeout !== 1'b0) begin n_bad++; $display("FAIL noto_recover got=%0d/%b/%b want=done/1/0", dn, pass, timeout); end
    repeat (3) @(negedge clock);
  endtask
`endif

  task automatic test_reset_mid;
    int nd;
    id_val = EXP_ID; ts_val = EXP_TS; stall_n = 10; nd = 0;
    @(negedge clock); start = 1;
    @(negedge clock); start = 0;
    repeat (2) @(negedge clock);
    n_cmp++; if (avm_read !== 1'b1 || avm_address !== 1'b0) begin n_bad++; $display("FAIL rst_pre got=%b%b want=10", avm_read, avm_address); end
    #2 reset = 1;
    #1;
    n_cmp++; if ({avm_read, avm_address, busy, done, pass, id_ok, ts_ok, timeout} !== 8'h00 || {read_id, read_ts} !== 64'h0) begin
      n_bad++; $display("FAIL rst_async got=%b %h want=00000000 0", {avm_read, avm_address, busy, done, pass, id_ok, ts_ok, timeout}, {read_id, read_ts}); end
    @(negedge clock); reset = 0;
    for (int n = 0; n < 15; n++) begin
      if (done === 1'b1 || busy === 1'b1 || avm_read === 1'b1) nd++;
      @(negedge clock);
    end
    n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL rst_idle got=%0d want=0", nd); end
    stall_n = 0;
  endtask

  initial begin
    test_reset;
    test_zero_wait;
    test_ts_mismatch;
    test_stall5;
    test_random;
    test_start_ignored;
    test_back_to_back;
    test_timeout;
    test_zero_wait;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
